vram_arbiter: RTL

//  Responder side of the video read bus: services the VGA scanout's one-cycle o_read/o_addr

---
 rtl/vram_arbiter_if.sv | 40 ++++
 rtl/vram_arbiter.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/vram_arbiter_if.sv
// Video-read, CPU and video-RAM signal bundle for vram_arbiter.
// slave = arbiter view, master = surrounding system view.
interface vram_arbiter_if #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 8
);
  logic [ADDR_W-1:0] i_vid_addr;
  logic              i_vid_read;
  logic [DATA_W-1:0] o_vid_data;
  logic              o_vid_ready;
  logic              o_vid_ovf;
  logic [ADDR_W-1:0] i_cpu_addr;
  logic [DATA_W-1:0] i_cpu_wdata;
  logic              i_cpu_wr;
  logic              i_cpu_rd;
  logic [DATA_W-1:0] o_cpu_rdata;
  logic              o_cpu_ack;
  logic [ADDR_W-1:0] o_mem_addr;
  logic              o_mem_we;
  logic [DATA_W-1:0] o_mem_wdata;
  logic [DATA_W-1:0] i_mem_rdata;

  modport slave (
    input  i_vid_addr, i_vid_read,
    output o_vid_data, o_vid_ready, o_vid_ovf,
    input  i_cpu_addr, i_cpu_wdata, i_cpu_wr, i_cpu_rd,
    output o_cpu_rdata, o_cpu_ack,
    output o_mem_addr, o_mem_we, o_mem_wdata,
    input  i_mem_rdata
  );

  modport master (
    output i_vid_addr, i_vid_read,
    input  o_vid_data, o_vid_ready, o_vid_ovf,
    output i_cpu_addr, i_cpu_wdata, i_cpu_wr, i_cpu_rd,
    input  o_cpu_rdata, o_cpu_ack,
    input  o_mem_addr, o_mem_we, o_mem_wdata,
    output i_mem_rdata
  );
endinterface

// File: rtl/vram_arbiter.sv
// Shares a single-port sync video RAM between VGA scanout reads
// and a CPU port; video first, strict alternation under contention.
module vram_arbiter #(
  parameter int ADDR_W  = 13,
  parameter int DATA_W  = 8,
  parameter int MEM_LAT = 1
) (
  input logic          i_clk,
  input logic          i_rst_n,
  vram_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    VID_RD,
    CPU_RD,
    CPU_WR
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              vid_pend_q, vid_pend_d;
  logic [ADDR_W-1:0] vid_addr_q, vid_addr_d;
  logic              last_vid_q, last_vid_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_we_q, mem_we_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] vid_data_q, vid_data_d;
  logic              vid_ready_q, vid_ready_d;
  logic              vid_ovf_q, vid_ovf_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic              cpu_ack_q, cpu_ack_d;

  logic cpu_req;
  logic vid_elig;
  logic vid_go;
  logic cpu_wr_go;
  logic cpu_rd_go;

  // A request still up during its own ack cycle is the one just served.
  assign cpu_req   = (bus.i_cpu_wr | bus.i_cpu_rd) & ~cpu_ack_q;
  assign vid_elig  = vid_pend_q | bus.i_vid_read;
  assign vid_go    = vid_elig & (~cpu_req | ~last_vid_q);
  assign cpu_wr_go = cpu_req & ~vid_go & bus.i_cpu_wr;
  assign cpu_rd_go = cpu_req & ~vid_go & ~bus.i_cpu_wr;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      vid_pend_q  <= 1'b0;
      vid_addr_q  <= '0;
      last_vid_q  <= 1'b0;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      vid_data_q  <= '0;
      vid_ready_q <= 1'b0;
      vid_ovf_q   <= 1'b0;
      cpu_rdata_q <= '0;
      cpu_ack_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      vid_pend_q  <= vid_pend_d;
      vid_addr_q  <= vid_addr_d;
      last_vid_q  <= last_vid_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      vid_data_q  <= vid_data_d;
      vid_ready_q <= vid_ready_d;
      vid_ovf_q   <= vid_ovf_d;
      cpu_rdata_q <= cpu_rdata_d;
      cpu_ack_q   <= cpu_ack_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    vid_pend_d  = vid_pend_q;
    vid_addr_d  = vid_addr_q;
    last_vid_d  = last_vid_q;
    mem_addr_d  = mem_addr_q;
    mem_we_d    = 1'b0;
    mem_wdata_d = mem_wdata_q;
    vid_data_d  = vid_data_q;
    vid_ready_d = 1'b0;
    vid_ovf_d   = vid_ovf_q;
    cpu_rdata_d = cpu_rdata_q;
    cpu_ack_d   = 1'b0;

    if (bus.i_vid_read) begin
      vid_pend_d = 1'b1;
      vid_addr_d = bus.i_vid_addr;
      if (vid_pend_q) begin
        vid_ovf_d = 1'b1;
      end
    end

    unique case (state_q)
      IDLE: begin
        unique case (1'b1)
          vid_go: begin
            // A strobe landing on the grant edge stays pending only
            // if an older one is the one being issued.
            mem_addr_d = vid_pend_q ? vid_addr_q : bus.i_vid_addr;
            vid_pend_d = vid_pend_q & bus.i_vid_read;
            last_vid_d = 1'b1;
            cnt_d      = 2'(MEM_LAT);
            state_d    = VID_RD;
          end
          cpu_wr_go: begin
            mem_addr_d  = bus.i_cpu_addr;
            mem_wdata_d = bus.i_cpu_wdata;
            mem_we_d    = 1'b1;
            last_vid_d  = 1'b0;
            state_d     = CPU_WR;
          end
          cpu_rd_go: begin
            mem_addr_d = bus.i_cpu_addr;
            last_vid_d = 1'b0;
            cnt_d      = 2'(MEM_LAT);
            state_d    = CPU_RD;
          end
          default: ;
        endcase
      end
      VID_RD: begin
        if (cnt_q == 2'd0) begin
          vid_data_d  = bus.i_mem_rdata;
          vid_ready_d = 1'b1;
          state_d     = IDLE;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      CPU_RD: begin
        if (cnt_q == 2'd0) begin
          cpu_rdata_d = bus.i_mem_rdata;
          cpu_ack_d   = 1'b1;
          state_d     = IDLE;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      CPU_WR: begin
        cpu_ack_d = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.o_vid_data  = vid_data_q;
  assign bus.o_vid_ready = vid_ready_q;
  assign bus.o_vid_ovf   = vid_ovf_q;
  assign bus.o_cpu_rdata = cpu_rdata_q;
  assign bus.o_cpu_ack   = cpu_ack_q;
  assign bus.o_mem_addr  = mem_addr_q;
  assign bus.o_mem_we    = mem_we_q;
  assign bus.o_mem_wdata = mem_wdata_q;

endmodule
